// File: rtl/dispatch_sequencer.sv
// dispatch_sequencer
// Accepts up to two renamed instructions per handshake, allocates sequential
// instruction IDs with matching ROB writes, holds the pair, and drains it into
// a single-write-port issue queue one entry per cycle, oldest first.
// A flush discards held entries and rewinds ID allocation past the flushing
// instruction; a rename walk (is_idle low) blocks acceptance but not draining.

module dispatch_sequencer #(
    parameter int PAYLOAD_W = 241,
    parameter int ID_W      = 7,
    parameter int ROB_SIZE  = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid0,
    input  logic                      in_valid1,
    output logic                      in_ready,
    input  logic [PAYLOAD_W-1:0]      in_payload0,
    input  logic [PAYLOAD_W-1:0]      in_payload1,
    input  logic [ID_W-1:0]           rob_cnt,
    output logic                      rob_wr0_valid,
    output logic [ID_W-1:0]           rob_wr0_id,
    output logic                      rob_wr1_valid,
    output logic [ID_W-1:0]           rob_wr1_id,
    output logic                      isq_wr_valid,
    input  logic                      isq_wr_ready,
    output logic [ID_W+PAYLOAD_W-1:0] isq_wr_data,
    input  logic                      flush_valid,
    input  logic [ID_W-1:0]           flush_id,
    input  logic                      is_idle
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD2 = 2'd1,
        ST_HOLD1 = 2'd2
    } state_t;

    // Capacity compare runs one bit wider than the count so rob_cnt+2 cannot wrap.
    localparam logic [ID_W:0] ROB_LIMIT = (ID_W+1)'(ROB_SIZE);
    localparam logic [ID_W-1:0] ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [ID_W-1:0]       r_next_id;
    logic [ID_W-1:0]       r_head_id;
    logic [PAYLOAD_W-1:0]  r_head_pl;
    logic [ID_W-1:0]       r_tail_id;
    logic [PAYLOAD_W-1:0]  r_tail_pl;

    logic [ID_W:0]         w_need;
    logic                  w_room;
    logic                  w_isq_valid;
    logic                  w_fire;
    logic                  w_slot_ok;
    logic                  w_ready;
    logic                  w_accept;
    logic [ID_W-1:0]       w_id_plus1;

    // Handshake decode: capacity, drain fire and pair acceptance for this cycle.
    always_comb begin
        w_need      = {{ID_W{1'b0}}, 1'b1} + {{ID_W{1'b0}}, in_valid1};
        w_room      = (({1'b0, rob_cnt} + w_need) <= ROB_LIMIT);
        w_isq_valid = (r_state != ST_EMPTY) && !flush_valid;
        w_fire      = w_isq_valid && isq_wr_ready;
        // A new pair may only land when nothing is held after this cycle's drain.
        w_slot_ok   = (r_state == ST_EMPTY) || ((r_state == ST_HOLD1) && w_fire);
        w_ready     = !flush_valid && is_idle && w_room && w_slot_ok;
        w_accept    = in_valid0 && w_ready;
        w_id_plus1  = r_next_id + ID_ONE;
    end

    // Drive handshake and ROB write outputs; IDs read as zero when not written.
    always_comb begin
        in_ready      = w_ready;
        isq_wr_valid  = w_isq_valid;
        rob_wr0_valid = w_accept;
        rob_wr1_valid = w_accept && in_valid1;
        if (w_accept) begin
            rob_wr0_id = r_next_id;
        end else begin
            rob_wr0_id = {ID_W{1'b0}};
        end
        if (w_accept && in_valid1) begin
            rob_wr1_id = w_id_plus1;
        end else begin
            rob_wr1_id = {ID_W{1'b0}};
        end
    end

    assign isq_wr_data = {r_head_id, r_head_pl};

    // Holding FSM: loads accepted pairs, shifts tail to head on drain, handles flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_next_id <= {ID_W{1'b0}};
            r_head_id <= {ID_W{1'b0}};
            r_head_pl <= {PAYLOAD_W{1'b0}};
            r_tail_id <= {ID_W{1'b0}};
            r_tail_pl <= {PAYLOAD_W{1'b0}};
        end else if (flush_valid) begin
            r_state   <= ST_EMPTY;
            r_next_id <= flush_id + ID_ONE;
        end else begin
            if (w_accept) begin
                r_head_id <= r_next_id;
                r_head_pl <= in_payload0;
                r_tail_id <= w_id_plus1;
                r_tail_pl <= in_payload1;
                r_next_id <= r_next_id + w_need[ID_W-1:0];
                r_state   <= in_valid1 ? ST_HOLD2 : ST_HOLD1;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        r_state <= ST_EMPTY;
                    end
                    ST_HOLD2: begin
                        if (w_fire) begin
                            r_head_id <= r_tail_id;
                            r_head_pl <= r_tail_pl;
                            r_state   <= ST_HOLD1;
                        end else begin
                            r_state   <= ST_HOLD2;
                        end
                    end
                    ST_HOLD1: begin
                        if (w_fire) begin
                            r_state <= ST_EMPTY;
                        end else begin
                            r_state <= ST_HOLD1;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Testbench for dispatch_sequencer: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.

module tb_dispatch_sequencer;

    localparam int PW = 241;
    localparam int IW = 7;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              in_valid0, in_valid1, in_ready;
    logic [PW-1:0]     in_payload0, in_payload1;
    logic [IW-1:0]     rob_cnt;
    logic              rob_wr0_valid, rob_wr1_valid;
    logic [IW-1:0]     rob_wr0_id, rob_wr1_id;
    logic              isq_wr_valid, isq_wr_ready;
    logic [IW+PW-1:0]  isq_wr_data;
    logic              flush_valid;
    logic [IW-1:0]     flush_id;
    logic              is_idle;

    dispatch_sequencer #(.PAYLOAD_W(PW), .ID_W(IW), .ROB_SIZE(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_ready(in_ready),
        .in_payload0(in_payload0), .in_payload1(in_payload1), .rob_cnt(rob_cnt),
        .rob_wr0_valid(rob_wr0_valid), .rob_wr0_id(rob_wr0_id),
        .rob_wr1_valid(rob_wr1_valid), .rob_wr1_id(rob_wr1_id),
        .isq_wr_valid(isq_wr_valid), .isq_wr_ready(isq_wr_ready), .isq_wr_data(isq_wr_data),
        .flush_valid(flush_valid), .flush_id(flush_id), .is_idle(is_idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t q[$];
    int   nid;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        logic [PW-1:0] v;
        v = {PW{1'b0}};
        for (int k = 0; k < 8; k++) v = (v << 32) | PW'($urandom);
        return v;
    endfunction

    // One cycle: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input logic v0, input logic v1, input int cnt, input logic rdy,
                        input logic fl, input int fid, input logic idle);
        bit   exp_rdy, exp_val, acc;
        int   need;
        ent_t e;
        @(negedge clock);
        in_valid0 = v0; in_valid1 = v1; rob_cnt = IW'(cnt);
        isq_wr_ready = rdy; flush_valid = fl; flush_id = IW'(fid); is_idle = idle;
        in_payload0 = rnd_pl(); in_payload1 = rnd_pl();
        #1;
        need    = v1 ? 2 : 1;
        exp_val = (q.size() > 0) && !fl;
        exp_rdy = !fl && idle && (cnt + need <= 64) &&
                  ((q.size() == 0) || (q.size() == 1 && exp_val && rdy));
        acc     = v0 && exp_rdy;
        check_val("in_ready", 256'(in_ready), 256'(exp_rdy));
        check_val("isq_valid", 256'(isq_wr_valid), 256'(exp_val));
        if (exp_val) check_val("isq_data", 256'(isq_wr_data), 256'({IW'(q[0].id), q[0].pl}));
        check_val("rob_wr0_valid", 256'(rob_wr0_valid), 256'(acc));
        check_val("rob_wr1_valid", 256'(rob_wr1_valid), 256'(acc && v1));
        if (acc) check_val("rob_wr0_id", 256'(rob_wr0_id), 256'(nid));
        if (acc && v1) check_val("rob_wr1_id", 256'(rob_wr1_id), 256'((nid + 1) % 128));
        @(posedge clock);
        if (fl) begin
            q.delete();
            nid = (fid + 1) % 128;
        end else begin
            if (exp_val && rdy) void'(q.pop_front());
            if (acc) begin
                e.id = nid; e.pl = in_payload0; q.push_back(e);
                if (v1) begin
                    e.id = (nid + 1) % 128; e.pl = in_payload1; q.push_back(e);
                end
                nid = (nid + need) % 128;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; rob_cnt = 7'd0;
        isq_wr_ready = 1'b0; flush_valid = 1'b0; flush_id = 7'd0; is_idle = 1'b0;
        in_payload0 = {PW{1'b0}}; in_payload1 = {PW{1'b0}};
        nid = 0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_in_ready", 256'(in_ready), 256'(0));
        check_val("rst_isq_valid", 256'(isq_wr_valid), 256'(0));
        check_val("rst_rob_wr0", 256'({rob_wr0_valid, rob_wr0_id}), 256'(0));
        check_val("rst_rob_wr1", 256'({rob_wr1_valid, rob_wr1_id}), 256'(0));
        check_val("rst_isq_data", 256'(isq_wr_data), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Single instructions back-to-back: ids 0,1,2, drained one per cycle.
        repeat (3) step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        // Pair ids 5,6 under backpressure, then release.
        step(1'b0, 1'b0, 0, 1'b1, 1'b1, 4, 1'b1);
        step(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        // ROB capacity: pair stalls whole at 63, single fits.
        step(1'b1, 1'b1, 63, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 63, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 64, 1'b1, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        // ID wrap: next id 127, pair gets 127 and 0.
        step(1'b0, 1'b0, 0, 1'b1, 1'b1, 126, 1'b1);
        step(1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        // Flush over a held pair 10,11 with a simultaneous request.
        step(1'b0, 1'b0, 0, 1'b1, 1'b1, 9, 1'b1);
        step(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1, 1'b1, 9, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        // Rename walk: held entry still drains, acceptance blocked.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        // Asynchronous reset while holding a pair.
        step(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        in_valid0 = 1'b0;
        #1;
        check_val("midrst_isq_valid", 256'(isq_wr_valid), 256'(0));
        check_val("midrst_isq_data", 256'(isq_wr_data), 256'(0));
        q.delete();
        nid = 0;
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int cnt;
            cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(62, 64) : $urandom_range(0, 60);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, cnt,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 127), $urandom_range(0, 19) < 17);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
